bus_xbar_rr: RTL and testbench

- Parametrised shared-bus interconnect; next generation of the fixed 4-master/8-slave shared bus.
- Arbitrates NUM_MASTERS requesters round-robin and muxes the granted master onto a single slave-side bus.
- Decodes the slave select from the upper address bits and returns the selected slave's read data and ready to the masters.
- Adds fairness, address-strobe-qualified chip selects, an owner/busy status output, and an optional transaction watchdog.

---
 rtl/bus_pkg.sv | 36 +++
 rtl/bus_rr_arbiter.sv | 119 +++++++++++
 rtl/bus_xbar_rr.sv | 138 +++++++++++++
 tb/tb_bus_xbar_rr.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared constants, default widths and helpers for the
//               round-robin shared-bus interconnect.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package bus_pkg;

    // Read/write encoding of the rw strobe
    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    // Levels for the active-low request/grant/strobe/select/ready lines
    localparam logic ENABLE_   = 1'b0;
    localparam logic DISABLE_  = 1'b1;

    // Default configuration
    localparam int BUS_NUM_MASTERS    = 4;
    localparam int BUS_NUM_SLAVES     = 8;
    localparam int BUS_ADDR_W         = 30;
    localparam int BUS_DATA_W         = 32;
    localparam int BUS_TIMEOUT_CYCLES = 255;

    // Ceiling log2, used for index widths at elaboration time
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_arbiter
// Description : Round-robin bus arbiter with a registered one-hot grant.
//               The owner keeps the bus until it drops its request; there is
//               no preemption. Grant, RR pointer and owner index live here.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = BUS_NUM_MASTERS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        i_req_,
    output logic [NUM_MASTERS-1:0]        o_grnt_,
    output logic [clog2(NUM_MASTERS)-1:0] o_owner
);

    localparam int c_OW = clog2(NUM_MASTERS);
    localparam int c_SW = c_OW + 1;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_OWNED = 1'b1;

    localparam logic [NUM_MASTERS-1:0] c_ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [NUM_MASTERS-1:0] w_req;
    // r_last is the RR pointer; it differs from r_owner only out of reset,
    // where the owner reads 0 but the pointer must give master 0 priority.
    logic [c_OW-1:0]        r_last;
    logic [c_OW-1:0]        r_owner;
    logic [c_OW-1:0]        w_pick;
    logic [c_SW-1:0]        w_scan;
    logic                   w_found;
    logic                   w_load;

    assign w_req = ~i_req_;

    // Find the first active requester after the last owner, wrapping round
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_scan = {1'b0, r_last} + c_SW'(i);
            if (w_scan >= c_SW'(NUM_MASTERS)) begin
                w_scan = w_scan - c_SW'(NUM_MASTERS);
            end
            if (!w_found && w_req[w_scan[c_OW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_scan[c_OW-1:0];
            end
        end
    end

    // State, grant, pointer and owner registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_grant <= '0;
            r_last  <= c_OW'(NUM_MASTERS - 1);
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_load) begin
                r_last  <= w_pick;
                r_owner <= w_pick;
            end
        end
    end

    // Next state: grant when idle, hand over only when the owner lets go
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_ST_OWNED;
                    w_load      = 1'b1;
                end
            end
            c_ST_OWNED: begin
                if (!w_req[r_owner]) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (w_load) begin
            w_grant_nxt = c_ONE << w_pick;
        end else if (w_state_nxt == c_ST_IDLE) begin
            w_grant_nxt = '0;
        end else begin
            w_grant_nxt = r_grant;
        end
    end

    // Outputs: active-low grant and the held owner index
    always_comb begin
        o_grnt_ = ~r_grant;
        o_owner = r_owner;
    end

endmodule : bus_rr_arbiter
`default_nettype wire

// File: rtl/bus_xbar_rr.sv
`default_nettype none
// ============================================================================
// Module      : bus_xbar_rr
// Description : Round-robin shared-bus interconnect. Muxes the granted master
//               onto the slave bus, decodes strobe-qualified chip selects from
//               the upper address bits and returns the selected slave's data
//               and ready. Define BUS_TIMEOUT_EN to add a transaction watchdog
//               that completes stalled accesses with m_err.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module bus_xbar_rr
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS    = BUS_NUM_MASTERS,
    parameter int NUM_SLAVES     = BUS_NUM_SLAVES,
    parameter int ADDR_W         = BUS_ADDR_W,
    parameter int DATA_W         = BUS_DATA_W,
    parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_req_,
    output logic [NUM_MASTERS-1:0]        m_grnt_,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]        m_as_,
    input  logic [NUM_MASTERS-1:0]        m_rw,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_as_,
    output logic                          s_rw,
    output logic [DATA_W-1:0]             s_wr_data,
    output logic [NUM_SLAVES-1:0]         s_cs_,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_rd_data,
    input  logic [NUM_SLAVES-1:0]         s_rdy_,
    output logic [DATA_W-1:0]             m_rd_data,
    output logic                          m_rdy_,
    output logic                          m_err,
    output logic [clog2(NUM_MASTERS)-1:0] bus_owner,
    output logic                          bus_busy
);

    localparam int c_SEL_W = clog2(NUM_SLAVES);

    logic [c_SEL_W-1:0] w_sel;
    logic [DATA_W-1:0]  w_slv_data;
    logic               w_slv_rdy_;

    bus_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_arbiter (
        .clk     (clk),
        .reset   (reset),
        .i_req_  (m_req_),
        .o_grnt_ (m_grnt_),
        .o_owner (bus_owner)
    );

    assign bus_busy = ~&m_grnt_;

    // Master mux: the registered grant picks which master drives the bus
    always_comb begin
        s_as_     = DISABLE_;
        s_rw      = BUS_READ;
        s_addr    = '0;
        s_wr_data = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (m_grnt_[i] == ENABLE_) begin
                s_as_     = m_as_[i];
                s_rw      = m_rw[i];
                s_addr    = m_addr[i*ADDR_W +: ADDR_W];
                s_wr_data = m_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sel = s_addr[ADDR_W-1 -: c_SEL_W];

    // Decoder: a chip select only fires while the address strobe is active
    always_comb begin
        s_cs_ = '1;
        if (s_as_ == ENABLE_) begin
            s_cs_[w_sel] = ENABLE_;
        end
    end

    // Slave mux: return data and ready from the one selected slave
    always_comb begin
        w_slv_data = '0;
        w_slv_rdy_ = DISABLE_;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            if (s_cs_[j] == ENABLE_) begin
                w_slv_data = s_rd_data[j*DATA_W +: DATA_W];
                w_slv_rdy_ = s_rdy_[j];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [15:0] r_wd_cnt;
    logic        w_timeout;

    // A real slave ready in the limit cycle wins over the watchdog
    assign w_timeout = (s_as_ == ENABLE_) && (w_slv_rdy_ == DISABLE_) &&
                       (r_wd_cnt == 16'(TIMEOUT_CYCLES));

    // Watchdog: count stalled strobe cycles, restart on completion or idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wd_cnt <= '0;
        end else if ((s_as_ == DISABLE_) || (m_rdy_ == ENABLE_)) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
        end
    end

    // Return path: a timeout forces a one-cycle error completion with zero data
    always_comb begin
        m_rd_data = w_slv_data;
        m_rdy_    = w_slv_rdy_;
        m_err     = 1'b0;
        if (w_timeout) begin
            m_rd_data = '0;
            m_rdy_    = ENABLE_;
            m_err     = 1'b1;
        end
    end
`else
    logic [15:0] w_unused_timeout;

    assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
    assign m_rd_data        = w_slv_data;
    assign m_rdy_           = w_slv_rdy_;
    assign m_err            = 1'b0;
`endif

endmodule : bus_xbar_rr
`default_nettype wire

// File: tb/tb_bus_xbar_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_xbar_rr
// Description : Scoreboard bench for bus_xbar_rr. Stimulus pushes expected
//               values tagged with the cycle they must appear in; a monitor on
//               the falling edge compares them, and pops expected read
//               completions whenever m_rdy_ is asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_xbar_rr;

    localparam int NM = 4;
    localparam int NS = 8;
    localparam int AW = 30;
    localparam int DW = 32;

    localparam int K_GRNT  = 0;
    localparam int K_OWNER = 1;
    localparam int K_BUSY  = 2;
    localparam int K_CS    = 3;
    localparam int K_SAS   = 4;
    localparam int K_SRW   = 5;
    localparam int K_ADDR  = 6;
    localparam int K_WDATA = 7;
    localparam int K_ERR   = 8;
    localparam int K_RDY   = 9;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       name;
    } rd_t;

    logic               clk;
    logic               reset;
    logic [NM-1:0]      m_req_;
    logic [NM-1:0]      m_grnt_;
    logic [NM*AW-1:0]   m_addr;
    logic [NM-1:0]      m_as_;
    logic [NM-1:0]      m_rw;
    logic [NM*DW-1:0]   m_wr_data;
    logic [AW-1:0]      s_addr;
    logic               s_as_;
    logic               s_rw;
    logic [DW-1:0]      s_wr_data;
    logic [NS-1:0]      s_cs_;
    logic [NS*DW-1:0]   s_rd_data;
    logic [NS-1:0]      s_rdy_;
    logic [DW-1:0]      m_rd_data;
    logic               m_rdy_;
    logic               m_err;
    logic [1:0]         bus_owner;
    logic               bus_busy;

    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    rd_t  rd_q[$];
    int   mon_i;
    logic [31:0] mon_act;
    exp_t mon_e;
    rd_t  mon_r;

    bus_xbar_rr #(
        .NUM_MASTERS    (NM),
        .NUM_SLAVES     (NS),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req_    (m_req_),
        .m_grnt_   (m_grnt_),
        .m_addr    (m_addr),
        .m_as_     (m_as_),
        .m_rw      (m_rw),
        .m_wr_data (m_wr_data),
        .s_addr    (s_addr),
        .s_as_     (s_as_),
        .s_rw      (s_rw),
        .s_wr_data (s_wr_data),
        .s_cs_     (s_cs_),
        .s_rd_data (s_rd_data),
        .s_rdy_    (s_rdy_),
        .m_rd_data (m_rd_data),
        .m_rdy_    (m_rdy_),
        .m_err     (m_err),
        .bus_owner (bus_owner),
        .bus_busy  (bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mon_actual(input int kind);
        case (kind)
            K_GRNT:  return {28'b0, m_grnt_};
            K_OWNER: return {30'b0, bus_owner};
            K_BUSY:  return {31'b0, bus_busy};
            K_CS:    return {24'b0, s_cs_};
            K_SAS:   return {31'b0, s_as_};
            K_SRW:   return {31'b0, s_rw};
            K_ADDR:  return {2'b0, s_addr};
            K_WDATA: return s_wr_data;
            K_ERR:   return {31'b0, m_err};
            K_RDY:   return {31'b0, m_rdy_};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: per-cycle expectations and read completions on m_rdy_
    always @(negedge clk) begin
        mon_i = 0;
        while (mon_i < exp_q.size()) begin
            mon_e = exp_q[mon_i];
            if (mon_e.cyc == cyc) begin
                mon_act = mon_actual(mon_e.kind);
                n_tests++;
                if (mon_act !== mon_e.val) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d): got %h expected %h",
                             mon_e.name, cyc, mon_act, mon_e.val);
                end
                exp_q.delete(mon_i);
            end else if (mon_e.cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: check for cycle %0d never sampled", mon_e.name, mon_e.cyc);
                exp_q.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
        if (m_rdy_ === 1'b0) begin
            n_tests++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rdy (cycle %0d): got data %h err %b expected no completion",
                         cyc, m_rd_data, m_err);
            end else begin
                mon_r = rd_q.pop_front();
                if (m_rd_data !== mon_r.data || m_err !== mon_r.err) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d): got data %h err %b expected data %h err %b",
                             mon_r.name, cyc, m_rd_data, m_err, mon_r.data, mon_r.err);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int d, input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + d;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic expect_rd(input logic [31:0] data, input logic err, input string nm);
        rd_t r;
        r.data = data;
        r.err  = err;
        r.name = nm;
        rd_q.push_back(r);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        expect_at(1, K_GRNT, 32'hF, "reset_grnt");
        expect_at(1, K_BUSY, 32'h0, "reset_busy");
        step();
        reset = 1'b1;
    endtask

    function automatic logic [31:0] grnt_of(input int m);
        logic [3:0] g;
        g = 4'hF;
        g[m] = 1'b0;
        return {28'b0, g};
    endfunction

    // Stimulus
    initial begin
        int o;
        int nx;
        reset  = 1'b0;
        m_req_ = '1;
        m_as_  = '1;
        m_rw   = '1;
        m_addr = '0;
        s_rdy_ = '1;
        for (int i = 0; i < NM; i++) m_wr_data[i*DW +: DW] = 32'hCAFE_0000 | 32'(i);
        for (int j = 0; j < NS; j++) s_rd_data[j*DW +: DW] = 32'h5A5A_0000 | 32'(j);
        s_rd_data[1*DW +: DW] = 32'hDEAD_BEEF;

        // Reset state, idle bus
        step();
        step();
        expect_at(0, K_GRNT,  32'hF,  "rst_grnt");
        expect_at(0, K_BUSY,  32'h0,  "rst_busy");
        expect_at(0, K_OWNER, 32'h0,  "rst_owner");
        expect_at(0, K_ERR,   32'h0,  "rst_err");
        expect_at(0, K_SAS,   32'h1,  "idle_s_as");
        expect_at(0, K_SRW,   32'h1,  "idle_s_rw");
        expect_at(0, K_ADDR,  32'h0,  "idle_s_addr");
        expect_at(0, K_WDATA, 32'h0,  "idle_s_wr_data");
        expect_at(0, K_CS,    32'hFF, "idle_cs");
        expect_at(0, K_RDY,   32'h1,  "idle_rdy");
        reset = 1'b1;
        step();

        // Single request and release
        m_req_ = 4'b1110;
        expect_at(1, K_GRNT,  32'hE, "single_grnt");
        expect_at(1, K_OWNER, 32'h0, "single_owner");
        expect_at(1, K_BUSY,  32'h1, "single_busy");
        step();
        m_req_ = 4'b1111;
        expect_at(1, K_GRNT,  32'hF, "single_release");
        expect_at(1, K_BUSY,  32'h0, "single_release_busy");
        expect_at(1, K_OWNER, 32'h0, "owner_holds_idle");
        step();

        // Round-robin fairness with everyone requesting
        do_reset();
        m_req_ = 4'b0000;
        expect_at(1, K_GRNT, grnt_of(0), "rr_first");
        step();
        for (int n = 0; n < 5; n++) begin
            o  = n % 4;
            nx = (n + 1) % 4;
            expect_at(1, K_GRNT, grnt_of(o), "rr_hold");
            step();
            m_req_[o] = 1'b1;
            expect_at(1, K_GRNT,  grnt_of(nx), "rr_next");
            expect_at(1, K_OWNER, 32'(nx),     "rr_owner");
            step();
            m_req_[o] = 1'b0;
        end
        m_req_ = 4'b1111;
        expect_at(1, K_GRNT, 32'hF, "rr_idle");
        step();

        // No preemption: master 2 keeps the bus while master 0 waits
        m_req_ = 4'b1011;
        expect_at(1, K_GRNT, grnt_of(2), "np_grant2");
        step();
        m_req_ = 4'b1010;
        expect_at(1, K_GRNT, grnt_of(2), "np_keep_a");
        step();
        expect_at(1, K_GRNT, grnt_of(2), "np_keep_b");
        step();
        m_req_ = 4'b1110;
        expect_at(1, K_GRNT,  grnt_of(0), "np_handover");
        expect_at(1, K_OWNER, 32'h0,      "np_owner0");
        step();
        m_req_ = 4'b1111;
        expect_at(1, K_GRNT, 32'hF, "np_idle");
        step();

        // Decode and mux with master 3 as owner
        m_req_ = 4'b0111;
        expect_at(1, K_GRNT, grnt_of(3), "dec_grant3");
        step();
        m_addr[3*AW +: AW] = 30'h0800_0000;
        m_addr[0*AW +: AW] = 30'h3000_0000;
        m_as_[3] = 1'b0;
        m_as_[0] = 1'b0;
        expect_at(0, K_ADDR, 32'h0800_0000, "dec_s_addr");
        expect_at(0, K_SAS,  32'h0,         "dec_s_as");
        expect_at(0, K_SRW,  32'h1,         "dec_s_rw_read");
        expect_at(0, K_CS,   32'hFD,        "dec_cs_s1");
        expect_at(0, K_RDY,  32'h1,         "dec_wait");
        step();
        s_rdy_[1] = 1'b0;
        expect_at(0, K_CS, 32'hFD, "dec_cs_s1_rdy");
        expect_rd(32'hDEAD_BEEF, 1'b0, "dec_rd_s1");
        step();
        s_rdy_   = '1;
        m_as_[3] = 1'b1;
        expect_at(0, K_CS,  32'hFF, "dec_cs_no_strobe");
        expect_at(0, K_SAS, 32'h1,  "dec_s_as_high");
        step();
        m_addr[3*AW +: AW] = 30'h2000_0000;
        m_as_[3]  = 1'b0;
        m_rw[3]   = 1'b0;
        s_rdy_[4] = 1'b0;
        expect_at(0, K_CS,    32'hEF,        "dec_cs_s4");
        expect_at(0, K_SRW,   32'h0,         "dec_s_rw_write");
        expect_at(0, K_WDATA, 32'hCAFE_0003, "dec_s_wr_data");
        expect_rd(32'h5A5A_0004, 1'b0, "dec_rd_s4");
        step();
        s_rdy_ = '1;
        m_as_  = '1;
        m_rw   = '1;
        m_req_ = 4'b1111;
        expect_at(0, K_SAS,  32'h1, "dec_end_s_as");
        expect_at(1, K_GRNT, 32'hF, "dec_idle");
        step();

        // Watchdog: master 0 stalls on slave 2
        m_req_ = 4'b1110;
        expect_at(1, K_GRNT, grnt_of(0), "wd_grant0");
        step();
        m_addr[0*AW +: AW] = 30'h1000_0000;
        m_as_[0] = 1'b0;
`ifdef BUS_TIMEOUT_EN
        for (int k = 0; k < 10; k++) begin
            if (k == 9) s_rdy_[2] = 1'b0;
            expect_at(0, K_ERR, (k == 4) ? 32'h1 : 32'h0, "wd_err");
            if (k == 4) expect_rd(32'h0, 1'b1, "wd_timeout");
            if (k == 9) expect_rd(32'h5A5A_0002, 1'b0, "wd_rdy_wins");
            if (k == 5) expect_at(0, K_GRNT, grnt_of(0), "wd_grant_kept");
            step();
        end
`else
        for (int k = 0; k < 6; k++) begin
            expect_at(0, K_ERR, 32'h0, "no_wd_err");
            step();
        end
`endif
        s_rdy_ = '1;
        m_as_  = '1;
        m_req_ = 4'b1111;
        expect_at(1, K_GRNT, 32'hF, "wd_idle");
        step();

        // Reset while master 1 is mid-transaction
        m_req_ = 4'b1101;
        expect_at(1, K_GRNT,  grnt_of(1), "mr_grant1");
        expect_at(1, K_OWNER, 32'h1,      "mr_owner1");
        step();
        m_addr[1*AW +: AW] = 30'h1800_0000;
        m_as_[1] = 1'b0;
        expect_at(0, K_CS, 32'hF7, "mr_cs_s3");
        reset = 1'b0;
        expect_at(1, K_GRNT,  32'hF,  "mr_grnt_dropped");
        expect_at(1, K_SAS,   32'h1,  "mr_s_as");
        expect_at(1, K_BUSY,  32'h0,  "mr_busy");
        expect_at(1, K_OWNER, 32'h0,  "mr_owner");
        expect_at(1, K_CS,    32'hFF, "mr_cs");
        step();
        reset  = 1'b1;
        m_as_  = '1;
        m_req_ = 4'b0000;
        expect_at(1, K_GRNT,  grnt_of(0), "mr_rr_restart");
        expect_at(1, K_OWNER, 32'h0,      "mr_rr_owner");
        step();
        m_req_ = 4'b1111;
        expect_at(1, K_GRNT, 32'hF, "mr_idle");
        step();
        step();
        step();

        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: check for cycle %0d left unsampled", mon_e.name, mon_e.cyc);
        end
        while (rd_q.size() > 0) begin
            mon_r = rd_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no completion expected data %h err %b",
                     mon_r.name, mon_r.data, mon_r.err);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL global_timeout: got no end of stimulus expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bus_xbar_rr
`default_nettype wire
